dma_mm2s_debug_engine: RTL and testbench

DMA_MM2S_DEBUG_ENGINE -- requirements
Module: dma_mm2s_debug_engine

---
 rtl/dma_mm2s_debug_engine.sv | 106 ++++++++++
 tb/tb_dma_mm2s_debug_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_mm2s_debug_engine.sv
// Debug MM2S engine: one AXI INCR read burst per start edge, forwarded to an
// AXI-Stream master with locally generated tlast and sticky error reporting.
module dma_mm2s_debug_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_len,
  input  logic [2:0]        cfg_size,
  input  logic              cfg_start,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              start_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [7:0]        cnt;
  logic              arvalid_q;
  logic              err_q;

  logic in_data, launch, r_hs, tlast_gen, beat_err;
  logic unused;

  assign unused    = m_axi_rresp[0];
  assign in_data   = (state == DATA);
  assign launch    = (state == IDLE) && cfg_start && !start_q;
  assign r_hs      = in_data && m_axi_rvalid && m_axis_tready;
  assign tlast_gen = in_data && (cnt == len_q);
  // rlast is only cross-checked; the beat count alone decides the burst end
  assign beat_err  = m_axi_rresp[1] || (m_axi_rlast != tlast_gen);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      start_q   <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt       <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q <= cfg_start;
      case (state)
        IDLE: if (launch) begin
          addr_q <= cfg_addr;
          len_q  <= cfg_len;
          size_q <= cfg_size;
          cnt    <= '0;
          if (cfg_size > MAX_SIZE) begin
            err_q <= 1'b1;
          end else begin
            err_q     <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: if (m_axi_arready) begin
          arvalid_q <= 1'b0;
          state     <= DATA;
        end
        DATA: if (r_hs) begin
          cnt <= cnt + 8'd1;
          if (beat_err) err_q <= 1'b1;
          if (tlast_gen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign err           = err_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = in_data && m_axis_tready;
  assign m_axis_tvalid = in_data && m_axi_rvalid;
  assign m_axis_tdata  = in_data ? m_axi_rdata : '0;
  assign m_axis_tlast  = tlast_gen;
endmodule

// File: tb/tb_dma_mm2s_debug_engine.sv
// Directed bench for dma_mm2s_debug_engine: an inline AXI slave drives beats,
// a scoreboard holds expected stream beats that a negedge monitor checks.
module tb_dma_mm2s_debug_engine;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              aclk, aresetn;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_len;
  logic [2:0]        cfg_size;
  logic              cfg_start;
  logic              busy, err;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast, m_axis_tvalid, m_axis_tready;

  dma_mm2s_debug_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_size(cfg_size), .cfg_start(cfg_start),
    .busy(busy), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [DATA_W-1:0] d; logic l; } beat_t;
  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ar_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AR handshake counter and stream scoreboard, sampled mid-cycle
  always @(negedge aclk) begin
    if (aresetn && m_axi_arvalid && m_axi_arready) ar_cnt++;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("tdata", m_axis_tdata, e.d);
        chk("tlast", m_axis_tlast, e.l);
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    cfg_addr = a; cfg_len = l; cfg_size = s; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // Present n beats; rresp=SLVERR on beat err_idx, rlast on beat rlast_idx.
  task automatic send(input int n, input int tag, input int err_idx, input int rlast_idx,
                      input bit toggle);
    for (int i = 0; i < n; i++) begin
      bit hs;
      logic [DATA_W-1:0] d;
      d = 32'hA000_0000 | DATA_W'(tag << 8) | DATA_W'(i);
      m_axi_rdata  = d;
      m_axi_rresp  = (i == err_idx) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == rlast_idx);
      m_axi_rvalid = 1'b1;
      sb.push_back('{d: d, l: (i == n - 1)});
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
        m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
        #1;
        chk("rready_mirror", m_axi_rready, m_axis_tready);
        chk("busy_in_data", busy, 1);
        hs = m_axi_rready;
        step();
      end
      if (!hs) chk("beat_timeout", 0, 1);
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    m_axis_tready = 1'b1;
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    aresetn = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_size = '0; cfg_start = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0; m_axis_tready = 1'b1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    aresetn = 1'b1;
    step();

    // basic 4-beat burst
    m_axi_arready = 1'b1;
    launch(32'h1000, 8'd3, 3'd2);
    chk("t1_busy_rise", busy, 1);
    chk("t1_arvalid", m_axi_arvalid, 1);
    chk("t1_araddr", m_axi_araddr, 32'h1000);
    chk("t1_arlen", m_axi_arlen, 3);
    chk("t1_arsize", m_axi_arsize, 2);
    chk("t1_arburst", m_axi_arburst, 2'b01);
    chk("t1_tvalid_addr", m_axis_tvalid, 0);
    chk("t1_rready_addr", m_axi_rready, 0);
    step();
    chk("t1_arvalid_drop", m_axi_arvalid, 0);
    chk("t1_ar_cnt", ar_cnt, 1);
    send(4, 1, -1, 3, 1'b0);
    chk("t1_busy_fall", busy, 0);
    chk("t1_err", err, 0);

    // single beat with delayed arready, launched on the first idle cycle
    m_axi_arready = 1'b0;
    launch(32'h2000, 8'd0, 3'd2);
    for (int k = 0; k < 5; k++) begin
      chk("t2_arvalid_hold", m_axi_arvalid, 1);
      chk("t2_araddr_hold", m_axi_araddr, 32'h2000);
      chk("t2_arlen_hold", m_axi_arlen, 0);
      step();
    end
    m_axi_arready = 1'b1;
    chk("t2_arvalid_6th", m_axi_arvalid, 1);
    step();
    m_axi_arready = 1'b0;
    chk("t2_ar_cnt", ar_cnt, 2);
    send(1, 2, -1, 0, 1'b0);
    chk("t2_idle", busy, 0);
    chk("t2_err", err, 0);

    // 8 beats with tready toggling every cycle
    m_axi_arready = 1'b1;
    launch(32'h3000, 8'd7, 3'd2);
    step();
    send(8, 3, -1, 7, 1'b1);
    chk("t3_idle", busy, 0);
    chk("t3_err", err, 0);
    chk("t3_ar_cnt", ar_cnt, 3);

    // SLVERR on beat 2, early rlast on beat 3
    launch(32'h4000, 8'd3, 3'd2);
    step();
    send(4, 4, 1, 2, 1'b0);
    chk("t4_idle", busy, 0);
    chk("t4_err", err, 1);
    step(); step();
    chk("t4_err_sticky", err, 1);

    // err cleared on launch; start edge during ADDR ignored
    m_axi_arready = 1'b0;
    launch(32'h5000, 8'd0, 3'd2);
    chk("t5_err_clear", err, 0);
    step();
    cfg_start = 1'b1;
    step(); step();
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    send(1, 5, -1, 0, 1'b0);
    chk("t5_idle", busy, 0);
    step(); step();
    chk("t5_no_relaunch", busy, 0);
    chk("t5_ar_cnt", ar_cnt, 5);
    cfg_start = 1'b0;
    step();

    // illegal size for a 32-bit bus
    launch(32'h6000, 8'd1, 3'd3);
    chk("t6_err", err, 1);
    chk("t6_busy", busy, 0);
    step(); step();
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_ar_cnt", ar_cnt, 5);

    // reset mid-transfer with cfg_start held high across release
    launch(32'h7000, 8'd0, 3'd2);
    chk("t7_busy", busy, 1);
    cfg_start = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_arvalid", m_axi_arvalid, 0);
    chk("t7_rst_err", err, 0);
    chk("t7_rst_araddr", m_axi_araddr, 0);
    step();
    aresetn = 1'b1;
    step(); step(); step();
    chk("t7_no_launch_busy", busy, 0);
    chk("t7_no_launch_arvalid", m_axi_arvalid, 0);
    chk("t7_ar_cnt", ar_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
